// File: rtl/rs_alu_dispatch_queue_pkg.sv
// Shared payload widths and the dispatch-queue entry format for the ALU reservation station path.
package rs_alu_dispatch_queue_pkg;

    localparam int XLEN               = 32;
    localparam int PHY_REG_ADDR_WIDTH = 6;
    localparam int ROB_INDEX_WIDTH    = 5;
    localparam int PC_WIDTH           = 32;
    localparam int IMM_LEN            = 32;

    typedef struct packed {
        logic [ROB_INDEX_WIDTH-1:0]    robID;
        logic [PC_WIDTH-1:0]           pc;
        logic [PC_WIDTH-1:0]           next_pc;
        logic [PC_WIDTH-1:0]           predict_pc;
        logic [PHY_REG_ADDR_WIDTH-1:0] prd;
        logic [PHY_REG_ADDR_WIDTH-1:0] prs1;
        logic [PHY_REG_ADDR_WIDTH-1:0] prs2;
        logic                          rs1_ready;
        logic                          rs2_ready;
        logic [XLEN-1:0]               data1;
        logic [XLEN-1:0]               data2;
        logic [IMM_LEN-1:0]            imm;
        logic [2:0]                    func3;
        logic                          func_modifier;
        logic [1:0]                    select_a;
        logic [1:0]                    select_b;
        logic                          half;
        logic                          jump;
        logic                          branch;
    } dq_alu_entry_t;

endpackage

// File: rtl/dq_wakeup_fwd.sv
// Combinational operand wakeup: applies the alu1/alu2/lsu writeback buses to one queue entry.
module dq_wakeup_fwd
    import rs_alu_dispatch_queue_pkg::*;
(
    input  dq_alu_entry_t                 entry,
    input  logic                          alu1_valid,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] alu1_prd,
    input  logic [XLEN-1:0]               alu1_data,
    input  logic                          alu2_valid,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] alu2_prd,
    input  logic [XLEN-1:0]               alu2_data,
    input  logic                          lsu_valid,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] lsu_prd,
    input  logic [XLEN-1:0]               lsu_data,
    output dq_alu_entry_t                 woken
);

    // Buses are checked alu1, alu2, lsu so the later match wins, mirroring the RS.
    always_comb begin
        woken = entry;
        if (!entry.rs1_ready) begin
            if (alu1_valid && alu1_prd == entry.prs1) begin
                woken.rs1_ready = 1'b1;
                woken.data1     = alu1_data;
            end
            if (alu2_valid && alu2_prd == entry.prs1) begin
                woken.rs1_ready = 1'b1;
                woken.data1     = alu2_data;
            end
            if (lsu_valid && lsu_prd == entry.prs1) begin
                woken.rs1_ready = 1'b1;
                woken.data1     = lsu_data;
            end
        end
        if (!entry.rs2_ready) begin
            if (alu1_valid && alu1_prd == entry.prs2) begin
                woken.rs2_ready = 1'b1;
                woken.data2     = alu1_data;
            end
            if (alu2_valid && alu2_prd == entry.prs2) begin
                woken.rs2_ready = 1'b1;
                woken.data2     = alu2_data;
            end
            if (lsu_valid && lsu_prd == entry.prs2) begin
                woken.rs2_ready = 1'b1;
                woken.data2     = lsu_data;
            end
        end
    end

endmodule

// File: rtl/rs_alu_dispatch_queue.sv
// In-order dual-width dispatch buffer between rename and the ALU RS, with writeback snooping.
// Optional synchronous flush port enabled by defining RS_ALU_DQ_FLUSH_EN.
module rs_alu_dispatch_queue
    import rs_alu_dispatch_queue_pkg::*;
#(
    parameter int DQ_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef RS_ALU_DQ_FLUSH_EN
    input  logic                          flush_i,
`endif
    input  logic                          in1_valid_i,
    input  logic                          in2_valid_i,
    input  dq_alu_entry_t                 in1_entry_i,
    input  dq_alu_entry_t                 in2_entry_i,
    output logic                          in_ready_o,
    output logic                          out1_valid_o,
    output logic                          out2_valid_o,
    output dq_alu_entry_t                 out1_entry_o,
    output dq_alu_entry_t                 out2_entry_o,
    input  logic                          rs_ready_first_i,
    input  logic                          rs_ready_second_i,
    input  logic                          alu1_done_valid_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] alu1_wb_prd_i,
    input  logic [XLEN-1:0]               alu1_wb_data_i,
    input  logic                          alu2_done_valid_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] alu2_wb_prd_i,
    input  logic [XLEN-1:0]               alu2_wb_data_i,
    input  logic                          lsu_done_valid_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] lsu_wb_prd_i,
    input  logic [XLEN-1:0]               lsu_wb_data_i
);

    localparam int IDX_W = $clog2(DQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head, tail, count, space, enq_n, deq_n;
    logic [IDX_W-1:0] head_idx, head_idx1, tail_idx, tail_idx1;
    logic             flush, enq1, enq2;

    dq_alu_entry_t ram    [DQ_DEPTH];
    dq_alu_entry_t ram_wk [DQ_DEPTH];
    dq_alu_entry_t in1_wk, in2_wk;

`ifdef RS_ALU_DQ_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Wrap-bit pointers: the difference is the occupancy, full when it equals DQ_DEPTH.
    assign count     = tail - head;
    assign space     = PTR_W'(DQ_DEPTH) - count;
    assign head_idx  = head[IDX_W-1:0];
    assign head_idx1 = head_idx + IDX_W'(1);
    assign tail_idx  = tail[IDX_W-1:0];
    assign tail_idx1 = tail_idx + IDX_W'(1);

    assign in_ready_o   = !flush && (space >= PTR_W'(2));
    assign out1_valid_o = !flush && (count != '0) && rs_ready_first_i;
    assign out2_valid_o = !flush && (count >= PTR_W'(2)) && rs_ready_first_i && rs_ready_second_i;

    assign enq1  = in1_valid_i && in_ready_o;
    assign enq2  = in1_valid_i && in2_valid_i && in_ready_o;
    assign enq_n = PTR_W'(enq1) + PTR_W'(enq2);
    assign deq_n = PTR_W'(out1_valid_o) + PTR_W'(out2_valid_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= tail;
        end else begin
            head <= head + deq_n;
            tail <= tail + enq_n;
        end
    end

    // Payload storage is not reset; entries are qualified by the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DQ_DEPTH; i++) ram[i] <= ram_wk[i];
        if (enq1) ram[tail_idx]  <= in1_wk;
        if (enq2) ram[tail_idx1] <= in2_wk;
    end

    for (genvar g = 0; g < DQ_DEPTH; g++) begin : g_store_wk
        dq_wakeup_fwd u_wk (
            .entry(ram[g]),
            .alu1_valid(alu1_done_valid_i), .alu1_prd(alu1_wb_prd_i), .alu1_data(alu1_wb_data_i),
            .alu2_valid(alu2_done_valid_i), .alu2_prd(alu2_wb_prd_i), .alu2_data(alu2_wb_data_i),
            .lsu_valid(lsu_done_valid_i),   .lsu_prd(lsu_wb_prd_i),   .lsu_data(lsu_wb_data_i),
            .woken(ram_wk[g])
        );
    end

    dq_wakeup_fwd u_in1_wk (
        .entry(in1_entry_i),
        .alu1_valid(alu1_done_valid_i), .alu1_prd(alu1_wb_prd_i), .alu1_data(alu1_wb_data_i),
        .alu2_valid(alu2_done_valid_i), .alu2_prd(alu2_wb_prd_i), .alu2_data(alu2_wb_data_i),
        .lsu_valid(lsu_done_valid_i),   .lsu_prd(lsu_wb_prd_i),   .lsu_data(lsu_wb_data_i),
        .woken(in1_wk)
    );

    dq_wakeup_fwd u_in2_wk (
        .entry(in2_entry_i),
        .alu1_valid(alu1_done_valid_i), .alu1_prd(alu1_wb_prd_i), .alu1_data(alu1_wb_data_i),
        .alu2_valid(alu2_done_valid_i), .alu2_prd(alu2_wb_prd_i), .alu2_data(alu2_wb_data_i),
        .lsu_valid(lsu_done_valid_i),   .lsu_prd(lsu_wb_prd_i),   .lsu_data(lsu_wb_data_i),
        .woken(in2_wk)
    );

    // The RS only snoops busy entries, so same-cycle wakeups must ride along on the way out.
    dq_wakeup_fwd u_out1_wk (
        .entry(ram[head_idx]),
        .alu1_valid(alu1_done_valid_i), .alu1_prd(alu1_wb_prd_i), .alu1_data(alu1_wb_data_i),
        .alu2_valid(alu2_done_valid_i), .alu2_prd(alu2_wb_prd_i), .alu2_data(alu2_wb_data_i),
        .lsu_valid(lsu_done_valid_i),   .lsu_prd(lsu_wb_prd_i),   .lsu_data(lsu_wb_data_i),
        .woken(out1_entry_o)
    );

    dq_wakeup_fwd u_out2_wk (
        .entry(ram[head_idx1]),
        .alu1_valid(alu1_done_valid_i), .alu1_prd(alu1_wb_prd_i), .alu1_data(alu1_wb_data_i),
        .alu2_valid(alu2_done_valid_i), .alu2_prd(alu2_wb_prd_i), .alu2_data(alu2_wb_data_i),
        .lsu_valid(lsu_done_valid_i),   .lsu_prd(lsu_wb_prd_i),   .lsu_data(lsu_wb_data_i),
        .woken(out2_entry_o)
    );

endmodule

// File: tb/tb_rs_alu_dispatch_queue.sv
// Directed self-checking bench for rs_alu_dispatch_queue; flush scenario built when RS_ALU_DQ_FLUSH_EN is defined.
module tb_rs_alu_dispatch_queue;
    import rs_alu_dispatch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic in1_valid, in2_valid, in_ready;
    dq_alu_entry_t in1_entry, in2_entry, out1_entry, out2_entry;
    logic out1_valid, out2_valid, rs_first, rs_second;
    logic alu1_v, alu2_v, lsu_v;
    logic [PHY_REG_ADDR_WIDTH-1:0] alu1_prd, alu2_prd, lsu_prd;
    logic [XLEN-1:0] alu1_data, alu2_data, lsu_data;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rs_alu_dispatch_queue #(.DQ_DEPTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef RS_ALU_DQ_FLUSH_EN
        .flush_i(flush),
`endif
        .in1_valid_i(in1_valid),
        .in2_valid_i(in2_valid),
        .in1_entry_i(in1_entry),
        .in2_entry_i(in2_entry),
        .in_ready_o(in_ready),
        .out1_valid_o(out1_valid),
        .out2_valid_o(out2_valid),
        .out1_entry_o(out1_entry),
        .out2_entry_o(out2_entry),
        .rs_ready_first_i(rs_first),
        .rs_ready_second_i(rs_second),
        .alu1_done_valid_i(alu1_v),
        .alu1_wb_prd_i(alu1_prd),
        .alu1_wb_data_i(alu1_data),
        .alu2_done_valid_i(alu2_v),
        .alu2_wb_prd_i(alu2_prd),
        .alu2_wb_data_i(alu2_data),
        .lsu_done_valid_i(lsu_v),
        .lsu_wb_prd_i(lsu_prd),
        .lsu_wb_data_i(lsu_data)
    );

    function automatic dq_alu_entry_t mk(input int rob, input int p1, input logic r1, input logic [31:0] d1,
                                         input int p2, input logic r2, input logic [31:0] d2);
        dq_alu_entry_t e;
        e = '0;
        e.robID     = ROB_INDEX_WIDTH'(rob);
        e.pc        = PC_WIDTH'(rob * 4);
        e.prd       = PHY_REG_ADDR_WIDTH'(rob + 32);
        e.prs1      = PHY_REG_ADDR_WIDTH'(p1);
        e.prs2      = PHY_REG_ADDR_WIDTH'(p2);
        e.rs1_ready = r1;
        e.rs2_ready = r2;
        e.data1     = d1;
        e.data2     = d2;
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        in1_valid = 1'b0; in2_valid = 1'b0;
        alu1_v = 1'b0; alu2_v = 1'b0; lsu_v = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drive_pair(input int rob);
        in1_entry = mk(rob, 1, 1'b1, 32'h0, 2, 1'b1, 32'h0);
        in2_entry = mk(rob + 1, 1, 1'b1, 32'h0, 2, 1'b1, 32'h0);
        in1_valid = 1'b1; in2_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); rs_first = 1'b1; rs_second = 1'b1;
        in1_entry = '0; in2_entry = '0;
        alu1_prd = '0; alu2_prd = '0; lsu_prd = '0; alu1_data = '0; alu2_data = '0; lsu_data = '0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out1_valid: got %b want 0", out1_valid); end
        n_cmp++; if (out2_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out2_valid: got %b want 0", out2_valid); end
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_dispatch_pair();
        tick(); drive_pair(1); rs_first = 1'b1; rs_second = 1'b1; #1;
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL pair_empty_v1: got %b want 0", out1_valid); end
        tick(); idle(); #1;
        n_cmp++; if (out1_valid !== 1'b1) begin n_fail++; $display("FAIL pair_v1: got %b want 1", out1_valid); end
        n_cmp++; if (out2_valid !== 1'b1) begin n_fail++; $display("FAIL pair_v2: got %b want 1", out2_valid); end
        n_cmp++; if (out1_entry.robID !== 5'd1) begin n_fail++; $display("FAIL pair_rob1: got %0d want 1", out1_entry.robID); end
        n_cmp++; if (out2_entry.robID !== 5'd2) begin n_fail++; $display("FAIL pair_rob2: got %0d want 2", out2_entry.robID); end
        tick(); #1;
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL pair_drained: got %b want 0", out1_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pair_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_partial_ready();
        tick(); drive_pair(5); rs_first = 1'b1; rs_second = 1'b0;
        tick(); idle(); #1;
        n_cmp++; if (out1_valid !== 1'b1) begin n_fail++; $display("FAIL part_v1: got %b want 1", out1_valid); end
        n_cmp++; if (out2_valid !== 1'b0) begin n_fail++; $display("FAIL part_v2: got %b want 0", out2_valid); end
        n_cmp++; if (out1_entry.robID !== 5'd5) begin n_fail++; $display("FAIL part_rob5: got %0d want 5", out1_entry.robID); end
        tick(); rs_second = 1'b1; #1;
        n_cmp++; if (out1_valid !== 1'b1) begin n_fail++; $display("FAIL part_v1b: got %b want 1", out1_valid); end
        n_cmp++; if (out2_valid !== 1'b0) begin n_fail++; $display("FAIL part_v2b: got %b want 0", out2_valid); end
        n_cmp++; if (out1_entry.robID !== 5'd6) begin n_fail++; $display("FAIL part_rob6: got %0d want 6", out1_entry.robID); end
        tick(); #1;
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL part_drained: got %b want 0", out1_valid); end
    endtask

    task automatic test_wakeup_queued();
        tick(); rs_first = 1'b0; rs_second = 1'b0;
        in1_entry = mk(7, 12, 1'b0, 32'h0, 3, 1'b1, 32'h33); in1_valid = 1'b1;
        tick(); idle(); #1;
        n_cmp++; if (out1_entry.rs1_ready !== 1'b0) begin n_fail++; $display("FAIL wq_not_ready: got %b want 0", out1_entry.rs1_ready); end
        alu2_v = 1'b1; alu2_prd = 6'd12; alu2_data = 32'hDEAD;
        tick(); alu2_v = 1'b0; rs_first = 1'b1; #1;
        n_cmp++; if (out1_valid !== 1'b1) begin n_fail++; $display("FAIL wq_v1: got %b want 1", out1_valid); end
        n_cmp++; if (out1_entry.rs1_ready !== 1'b1) begin n_fail++; $display("FAIL wq_rs1_ready: got %b want 1", out1_entry.rs1_ready); end
        n_cmp++; if (out1_entry.data1 !== 32'hDEAD) begin n_fail++; $display("FAIL wq_data1: got %h want dead", out1_entry.data1); end
        n_cmp++; if (out1_entry.data2 !== 32'h33) begin n_fail++; $display("FAIL wq_data2: got %h want 33", out1_entry.data2); end
        tick(); #1;
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL wq_drained: got %b want 0", out1_valid); end
    endtask

    task automatic test_wakeup_priority();
        tick(); rs_first = 1'b0; rs_second = 1'b0;
        in1_entry = mk(8, 4, 1'b1, 32'h44, 7, 1'b0, 32'h0); in1_valid = 1'b1;
        tick(); idle();
        alu1_v = 1'b1; alu1_prd = 6'd7; alu1_data = 32'h1;
        lsu_v = 1'b1; lsu_prd = 6'd7; lsu_data = 32'h2;
        rs_first = 1'b1; #1;
        n_cmp++; if (out1_valid !== 1'b1) begin n_fail++; $display("FAIL prio_v1: got %b want 1", out1_valid); end
        n_cmp++; if (out1_entry.rs2_ready !== 1'b1) begin n_fail++; $display("FAIL prio_rs2_ready: got %b want 1", out1_entry.rs2_ready); end
        n_cmp++; if (out1_entry.data2 !== 32'h2) begin n_fail++; $display("FAIL prio_data2: got %h want 2", out1_entry.data2); end
        n_cmp++; if (out1_entry.data1 !== 32'h44) begin n_fail++; $display("FAIL prio_data1: got %h want 44", out1_entry.data1); end
        tick(); idle(); #1;
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL prio_drained: got %b want 0", out1_valid); end
    endtask

    task automatic test_enqueue_wakeup();
        tick(); rs_first = 1'b0; rs_second = 1'b0;
        in1_entry = mk(9, 20, 1'b0, 32'h0, 21, 1'b0, 32'h0);
        in2_entry = mk(10, 20, 1'b0, 32'h0, 5, 1'b1, 32'h77);
        in1_valid = 1'b1; in2_valid = 1'b1;
        alu1_v = 1'b1; alu1_prd = 6'd20; alu1_data = 32'h55;
        lsu_v = 1'b1; lsu_prd = 6'd21; lsu_data = 32'h66;
        tick(); idle(); rs_first = 1'b1; #1;
        n_cmp++; if (out1_entry.robID !== 5'd9) begin n_fail++; $display("FAIL enqwk_rob9: got %0d want 9", out1_entry.robID); end
        n_cmp++; if (out1_entry.data1 !== 32'h55 || out1_entry.rs1_ready !== 1'b1) begin n_fail++; $display("FAIL enqwk_in1_src1: got %b/%h want 1/55", out1_entry.rs1_ready, out1_entry.data1); end
        n_cmp++; if (out1_entry.data2 !== 32'h66 || out1_entry.rs2_ready !== 1'b1) begin n_fail++; $display("FAIL enqwk_in1_src2: got %b/%h want 1/66", out1_entry.rs2_ready, out1_entry.data2); end
        n_cmp++; if (out2_entry.data1 !== 32'h55 || out2_entry.rs1_ready !== 1'b1) begin n_fail++; $display("FAIL enqwk_in2_src1: got %b/%h want 1/55", out2_entry.rs1_ready, out2_entry.data1); end
        tick(); #1;
        n_cmp++; if (out1_valid !== 1'b1 || out1_entry.robID !== 5'd10) begin n_fail++; $display("FAIL enqwk_rob10: got %b/%0d want 1/10", out1_valid, out1_entry.robID); end
        tick(); #1;
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL enqwk_drained: got %b want 0", out1_valid); end
    endtask

    task automatic test_no_overwrite();
        tick(); rs_first = 1'b0; rs_second = 1'b0;
        in1_entry = mk(11, 3, 1'b1, 32'h11, 3, 1'b1, 32'h22); in1_valid = 1'b1;
        alu1_v = 1'b1; alu1_prd = 6'd3; alu1_data = 32'h99;
        tick(); in1_valid = 1'b0; rs_first = 1'b1; #1;
        n_cmp++; if (out1_entry.data1 !== 32'h11) begin n_fail++; $display("FAIL noovr_data1: got %h want 11", out1_entry.data1); end
        n_cmp++; if (out1_entry.data2 !== 32'h22) begin n_fail++; $display("FAIL noovr_data2: got %h want 22", out1_entry.data2); end
        tick(); idle(); #1;
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL noovr_drained: got %b want 0", out1_valid); end
    endtask

    task automatic test_fill_full();
        rs_first = 1'b0; rs_second = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); drive_pair(16 + 2 * k); #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready_%0d: got %b want 1", k, in_ready); end
        end
        tick(); idle(); #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready8: got %b want 0", in_ready); end
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL full_held: got %b want 0", out1_valid); end
        rs_first = 1'b1; rs_second = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_credit: got %b want 0", in_ready); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out1_valid !== 1'b1 || out2_valid !== 1'b1) begin n_fail++; $display("FAIL full_drain_v_%0d: got %b%b want 11", k, out1_valid, out2_valid); end
            n_cmp++; if (out1_entry.robID !== ROB_INDEX_WIDTH'(16 + 2 * k) || out2_entry.robID !== ROB_INDEX_WIDTH'(17 + 2 * k)) begin
                n_fail++; $display("FAIL full_drain_rob_%0d: got %0d,%0d want %0d,%0d", k, out1_entry.robID, out2_entry.robID, 16 + 2 * k, 17 + 2 * k);
            end
            tick(); #1;
        end
        n_cmp++; if (out1_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_empty: got v1=%b rdy=%b want 0,1", out1_valid, in_ready); end
    endtask

    task automatic test_count7();
        rs_first = 1'b0; rs_second = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); drive_pair(24 + 2 * k); end
        tick(); idle(); in1_entry = mk(30, 1, 1'b1, 32'h0, 2, 1'b1, 32'h0); in1_valid = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL c7_in_ready6: got %b want 1", in_ready); end
        tick(); idle(); #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL c7_in_ready7: got %b want 0", in_ready); end
        rs_first = 1'b1; rs_second = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out2_valid !== 1'b1 || out1_entry.robID !== ROB_INDEX_WIDTH'(24 + 2 * k) || out2_entry.robID !== ROB_INDEX_WIDTH'(25 + 2 * k)) begin
                n_fail++; $display("FAIL c7_drain_%0d: got v2=%b %0d,%0d want 1 %0d,%0d", k, out2_valid, out1_entry.robID, out2_entry.robID, 24 + 2 * k, 25 + 2 * k);
            end
            tick(); #1;
        end
        n_cmp++; if (out1_valid !== 1'b1 || out2_valid !== 1'b0 || out1_entry.robID !== 5'd30) begin
            n_fail++; $display("FAIL c7_last: got %b%b rob %0d want 10 rob 30", out1_valid, out2_valid, out1_entry.robID);
        end
        tick(); #1;
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL c7_empty: got %b want 0", out1_valid); end
    endtask

`ifdef RS_ALU_DQ_FLUSH_EN
    task automatic test_flush();
        rs_first = 1'b0; rs_second = 1'b0;
        tick(); drive_pair(1);
        tick(); drive_pair(3);
        tick(); idle(); flush = 1'b1; rs_first = 1'b1; rs_second = 1'b1;
        in1_entry = mk(5, 1, 1'b1, 32'h0, 2, 1'b1, 32'h0); in1_valid = 1'b1; #1;
        n_cmp++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valids: got %b%b want 00", out1_valid, out2_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick(); idle(); #1;
        n_cmp++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", out1_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready_after: got %b want 1", in_ready); end
    endtask
`endif

    task automatic test_reset_mid();
        rs_first = 1'b0; rs_second = 1'b0;
        tick(); drive_pair(12);
        tick(); idle(); rs_first = 1'b1; rs_second = 1'b1; #1;
        n_cmp++; if (out1_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_before: got %b want 1", out1_valid); end
        rst_n = 1'b0; #1;
        n_cmp++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got %b%b want 00", out1_valid, out2_valid); end
        tick(); rst_n = 1'b1; #1;
        n_cmp++; if (out1_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after: got v1=%b rdy=%b want 0,1", out1_valid, in_ready); end
    endtask

    initial begin
        test_reset();
        test_dispatch_pair();
        test_partial_ready();
        test_wakeup_queued();
        test_wakeup_priority();
        test_enqueue_wakeup();
        test_no_overwrite();
        test_fill_full();
        test_count7();
`ifdef RS_ALU_DQ_FLUSH_EN
        test_flush();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
